// File: rtl/rlc_game_button_pio_in.sv
// rlc_game_button_pio_in: Avalon-MM input PIO with synchronizer, per-bit debounce,
// edge capture (write-1-to-clear) and a maskable level interrupt.
module rlc_game_button_pio_in #(
    parameter int WIDTH = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q, deb_q, deb_d, deb_dly_q;
    logic [WIDTH-1:0] mask_q, mask_d, cap_q, cap_d;
    logic [WIDTH-1:0] rise, fall, ev, rd;
    logic             wr;
    logic             unused_wd;

    assign wr        = chipselect && !write_n;
    assign unused_wd = ^writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_deb
        logic [CW-1:0] cnt_q;
        logic          diff, hit;
        assign diff     = sync2_q[i] ^ deb_q[i];
        assign hit      = cnt_q == CNT_MAX;
        assign deb_d[i] = (diff && hit) ? sync2_q[i] : deb_q[i];
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) cnt_q <= '0;
            else          cnt_q <= (!diff || hit) ? '0 : cnt_q + CW'(1);
        end
    end

    // deb_dly_q resets to the same value as deb_q, so reset release never looks like an edge
    assign rise = deb_q & ~deb_dly_q;
    assign fall = ~deb_q & deb_dly_q;
    assign ev   = (EDGE_TYPE == 0) ? rise : (EDGE_TYPE == 1) ? fall : (rise | fall);

    assign mask_d = (wr && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;
    // a new edge event wins over a simultaneous software clear
    assign cap_d  = (cap_q & ~((wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0)) | ev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= RESET_VALUE;
            sync2_q   <= RESET_VALUE;
            deb_q     <= RESET_VALUE;
            deb_dly_q <= RESET_VALUE;
            mask_q    <= '0;
            cap_q     <= '0;
        end else begin
            sync1_q   <= in_port;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            mask_q    <= mask_d;
            cap_q     <= cap_d;
        end
    end

    always_comb begin
        rd = (address == 2'd0) ? deb_q : (address == 2'd2) ? mask_q : (address == 2'd3) ? cap_q : '0;
        readdata = 32'(rd);
    end

    assign irq = |(cap_q & mask_q);
endmodule

// File: tb/tb_rlc_game_button_pio_in.sv
// tb_rlc_game_button_pio_in: directed checks of register map, debounce, edge capture and irq.
module tb_rlc_game_button_pio_in;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [3:0]  in_port = 4'hF;
    logic [31:0] readdata;
    logic        irq;
    int          checks = 0;
    int          errors = 0;

    rlc_game_button_pio_in #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .RESET_VALUE(4'hF)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        address = a;
        #1;
        v = readdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a;
        writedata = d;
        chipselect = 1'b1;
        write_n = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        repeat (2) tick();
        rd(2'd0, v); checks++;
        if (v !== 32'h0000000F) begin errors++; $display("FAIL reset_data got %h exp %h", v, 32'hF); end
        rd(2'd2, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL reset_mask got %h exp %h", v, 32'h0); end
        rd(2'd3, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL reset_cap got %h exp %h", v, 32'h0); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
        reset_n = 1'b1;
        repeat (8) tick();
        rd(2'd3, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL release_cap got %h exp %h", v, 32'h0); end
        rd(2'd1, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL addr1 got %h exp %h", v, 32'h0); end
        wr(2'd0, 32'h0); rd(2'd0, v); checks++;
        if (v !== 32'hF) begin errors++; $display("FAIL data_ro got %h exp %h", v, 32'hF); end
    endtask

    task automatic test_fall_capture();
        logic [31:0] v;
        wr(2'd2, 32'hFFFF_FFF1);
        rd(2'd2, v); checks++;
        if (v !== 32'h1) begin errors++; $display("FAIL mask_wr got %h exp %h", v, 32'h1); end
        in_port = 4'hE;
        repeat (5) tick();
        rd(2'd0, v); checks++;
        if (v !== 32'hF) begin errors++; $display("FAIL data_k4 got %h exp %h", v, 32'hF); end
        tick();
        rd(2'd0, v); checks++;
        if (v !== 32'hE) begin errors++; $display("FAIL data_k5 got %h exp %h", v, 32'hE); end
        rd(2'd3, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL cap_k5 got %h exp %h", v, 32'h0); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_k5 got %b exp 0", irq); end
        tick();
        rd(2'd3, v); checks++;
        if (v !== 32'h1) begin errors++; $display("FAIL cap_k6 got %h exp %h", v, 32'h1); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_k6 got %b exp 1", irq); end
        wr(2'd3, 32'h1);
        rd(2'd3, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL cap_clr got %h exp %h", v, 32'h0); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_clr got %b exp 0", irq); end
    endtask

    task automatic test_glitch();
        logic [31:0] v;
        in_port = 4'hF;
        repeat (10) tick();
        rd(2'd3, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL rise_no_cap got %h exp %h", v, 32'h0); end
        in_port = 4'hD;
        repeat (3) tick();
        in_port = 4'hF;
        repeat (3) tick();
        rd(2'd0, v); checks++;
        if (v !== 32'hF) begin errors++; $display("FAIL glitch_mid got %h exp %h", v, 32'hF); end
        repeat (7) tick();
        rd(2'd0, v); checks++;
        if (v !== 32'hF) begin errors++; $display("FAIL glitch_data got %h exp %h", v, 32'hF); end
        rd(2'd3, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL glitch_cap got %h exp %h", v, 32'h0); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL glitch_irq got %b exp 0", irq); end
    endtask

    task automatic test_w1c_mask();
        logic [31:0] v;
        wr(2'd2, 32'h0);
        in_port = 4'hC;
        repeat (8) tick();
        rd(2'd3, v); checks++;
        if (v !== 32'h3) begin errors++; $display("FAIL cap_two got %h exp %h", v, 32'h3); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked got %b exp 0", irq); end
        wr(2'd2, 32'h2);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_unmask got %b exp 1", irq); end
        wr(2'd3, 32'h1);
        rd(2'd3, v); checks++;
        if (v !== 32'h2) begin errors++; $display("FAIL w1c_bit0 got %h exp %h", v, 32'h2); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_keep got %b exp 1", irq); end
        wr(2'd3, 32'h2);
        rd(2'd3, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL w1c_bit1 got %h exp %h", v, 32'h0); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_drop got %b exp 0", irq); end
    endtask

    task automatic test_set_wins();
        logic [31:0] v;
        wr(2'd2, 32'h4);
        in_port = 4'h8;
        tick();
        repeat (5) tick();
        rd(2'd3, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL pre_setwin got %h exp %h", v, 32'h0); end
        wr(2'd3, 32'hF);
        rd(2'd3, v); checks++;
        if (v !== 32'h4) begin errors++; $display("FAIL set_wins got %h exp %h", v, 32'h4); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_setwin got %b exp 1", irq); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        in_port = 4'h0;
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        rd(2'd0, v); checks++;
        if (v !== 32'hF) begin errors++; $display("FAIL mid_rst_data got %h exp %h", v, 32'hF); end
        rd(2'd2, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL mid_rst_mask got %h exp %h", v, 32'h0); end
        rd(2'd3, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL mid_rst_cap got %h exp %h", v, 32'h0); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL mid_rst_irq got %b exp 0", irq); end
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (5) tick();
        rd(2'd0, v); checks++;
        if (v !== 32'hF) begin errors++; $display("FAIL rel_data_j4 got %h exp %h", v, 32'hF); end
        tick();
        rd(2'd0, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL rel_data_j5 got %h exp %h", v, 32'h0); end
        rd(2'd3, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL rel_cap_j5 got %h exp %h", v, 32'h0); end
        tick();
        rd(2'd3, v); checks++;
        if (v !== 32'hF) begin errors++; $display("FAIL rel_cap_j6 got %h exp %h", v, 32'hF); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL rel_irq got %b exp 0", irq); end
        wr(2'd2, 32'h8);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL rel_irq_mask got %b exp 1", irq); end
    endtask

    initial begin
        test_reset();
        test_fall_capture();
        test_glitch();
        test_w1c_mask();
        test_set_wins();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rlc_game_button_pio_in.md
Name: rlc_game_button_pio_in

Overview:
- Avalon-MM slave input PIO: the read-side counterpart of the seven-segment output PIO in the RLC game Qsys system.
- Samples external push-buttons/switches on in_port, synchronizes and debounces them, and latches edges in an edge-capture register.
- Raises a maskable level interrupt to the Nios II processor.
- Software sees the same 2-bit register map style as the existing output PIOs.

Parameters:
- WIDTH, 4, number of input bits (1..32).
- DEBOUNCE_CYCLES, 50000, consecutive clk cycles a synchronized input must differ from the debounced value before it is accepted (>=1; 1 ms at 50 MHz).
- EDGE_TYPE, 1, edge-capture sense per bit: 0 = rising, 1 = falling, 2 = any.
- RESET_VALUE, all ones (WIDTH bits), reset value of the synchronizer flops and the debounced value (buttons idle high).

Ports:
- clk  input  1  system clock; all flops on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- address  input  2  Avalon register word address.
- chipselect  input  1  Avalon slave select.
- write_n  input  1  Avalon write strobe, active low.
- writedata  input  32  Avalon write data.
- in_port  input  WIDTH  asynchronous external inputs.
- readdata  output  32  Avalon read data, combinational from address (zero wait states, zero read latency).
- irq  output  1  level interrupt, active high.

Behaviour:
- Register map:
  - addr 0 DATA: read-only, debounced value; writes ignored.
  - addr 1: reads 0; writes ignored.
  - addr 2 IRQMASK: read/write, WIDTH bits.
  - addr 3 EDGECAPTURE: read; a write clears every bit whose writedata bit is 1 (write-1-to-clear).
- readdata bits [31:WIDTH] are always 0.
- A write occurs when chipselect && !write_n.
- Reset (asynchronous, any time, including mid-debounce):
  - sync1, sync2, deb and deb_d go to RESET_VALUE.
  - Debounce counters go to 0.
  - IRQMASK and EDGECAPTURE go to 0.
  - irq = 0. readdata follows its combinational definition.
  - Reset release must not produce an edge.
- Synchronizer: 2-flop chain in_port -> sync1 -> sync2.
- Debounce, per bit, each clk edge:
  - If sync2 == deb: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: deb <= sync2, counter <= 0.
  - Else: counter <= counter+1.
  - Counter width is clog2(DEBOUNCE_CYCLES), minimum 1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches deb; the counter restarts from 0 when the glitch ends.
- Latency: if in_port changes before edge k and then stays stable, DATA reflects it after edge k+1+DEBOUNCE_CYCLES.
- Edge detect: deb_d <= deb every cycle. Per-bit edge event:
  - rise = deb & ~deb_d
  - fall = ~deb & deb_d
  - selected by EDGE_TYPE.
- An edge event sets the EDGECAPTURE bit on the next clk edge, i.e. edge k+2+DEBOUNCE_CYCLES. Bits stay set until cleared by software.
- Simultaneous clear-write and new edge event on the same bit: set wins.
- Writes to the other bits clear normally.
- irq = |(EDGECAPTURE & IRQMASK), combinational from the registers (no extra cycle).
- Writing IRQMASK with pending captured bits asserts irq immediately after that write edge.
- Unused writedata bits are ignored.

Test Plan (WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=1, RESET_VALUE=4'hF):
1. Reset, in_port=4'hF -> read addr0 = 32'h0000000F; addr2 = 0; addr3 = 0; irq=0; no capture after reset release.
2. in_port bit0 goes 1->0 before edge k and holds; IRQMASK=4'h1 -> addr0 reads 4'hE from after edge k+5; addr3 reads 4'h1 and irq=1 from after edge k+6.
3. in_port bit1 low pulse lasting 3 cycles, then back high -> addr0 stays 4'hF; addr3 stays 0; irq stays 0.
4. addr3=4'h3 pending, IRQMASK=4'h2, write addr3 with 32'h1 -> addr3 = 4'h2 and irq stays 1; then write 32'h2 -> addr3 = 0 and irq=0.
5. Clear-write to addr3 bit2 in the same cycle as a new bit2 fall event -> bit2 remains 1.
6. Assert reset_n=0 mid-debounce (counter=2) and mid-capture -> all registers return to reset values immediately; after release with in_port low, the debounced fall is recaptured normally (2+4 cycles).
